// File: rtl/uart_xcvr_param_if.sv
// ----------------------------------------------------------------------------
// uart_xcvr_param_if
// Word-level handshake bundle between the UART transceiver and its user logic.
//
//   tx_data / tx_valid / tx_ready : word to transmit, valid/ready handshake
//   tx_busy                       : a frame is being shifted out on the line
//   rx_data / rx_valid / rx_ready : received word, valid/ready handshake
//   rx_parity_err / rx_frame_err  : error flags for the word in rx_data
//   rx_overrun                    : sticky, an unread word was overwritten
//
// Modports: master = user logic, slave = transceiver.
// ----------------------------------------------------------------------------
interface uart_xcvr_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_busy;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_parity_err;
    logic              rx_frame_err;
    logic              rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, tx_busy, rx_data, rx_valid,
        input  rx_parity_err, rx_frame_err, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, tx_busy, rx_data, rx_valid,
        output rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_xcvr_param.sv
// ----------------------------------------------------------------------------
// uart_xcvr_param
// Full-duplex UART with configurable data width (5..9), parity (none/even/odd)
// and 1 or 2 transmitted stop bits, plus a one-entry receive holding register
// with parity, framing and overrun reporting.
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   en       link enable (gates new TX words, forces RX to idle when low)
//   bus      uart_xcvr_param_if.slave, word handshakes for both directions
//   uart_tx  serial output, idle high
//   uart_rx  serial input, asynchronous to clk
// ----------------------------------------------------------------------------
module uart_xcvr_param #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    uart_xcvr_param_if.slave   bus,
    output logic               uart_tx,
    input  logic               uart_rx
);
    // Rounded clocks per bit.
    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W = (STOP_BITS * DIV > 1) ? $clog2(STOP_BITS * DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic             ODD       = (PARITY == 2);

    generate
        if (DIV < 4) begin : g_div_chk
            $error("uart_xcvr_param: CLK_HZ/BAUD must give at least 4 clocks per bit");
        end
        if (DATA_W < 5 || DATA_W > 9) begin : g_width_chk
            $error("uart_xcvr_param: DATA_W must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_parity_chk
            $error("uart_xcvr_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
            $error("uart_xcvr_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    tx_state_t         tx_state_q;
    logic [CNT_W-1:0]  tx_cnt_q;
    logic [BIT_W-1:0]  tx_bit_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic              tx_par_q;
    logic              tx_q;
    logic              tx_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (bus.tx_valid && tx_ready_q) begin
                        tx_shift_q <= bus.tx_data;
                        tx_par_q   <= (^bus.tx_data) ^ ODD;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= BIT_LOAD;
                        tx_ready_q <= 1'b0;
                        tx_state_q <= TX_START;
                    end else begin
                        tx_ready_q <= en;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == '0) begin
                        tx_q       <= tx_shift_q[0];
                        tx_bit_q   <= '0;
                        tx_cnt_q   <= BIT_LOAD;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == '0) begin
                        if (tx_bit_q == LAST_BIT) begin
                            if (PARITY != 0) begin
                                tx_q       <= tx_par_q;
                                tx_cnt_q   <= BIT_LOAD;
                                tx_state_q <= TX_PARITY;
                            end else begin
                                tx_q       <= 1'b1;
                                tx_cnt_q   <= STOP_LOAD;
                                tx_state_q <= TX_STOP;
                            end
                        end else begin
                            // Bit 1 of the shifter is the next bit to send.
                            tx_q       <= tx_shift_q[1];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_bit_q   <= tx_bit_q + BIT_W'(1);
                            tx_cnt_q   <= BIT_LOAD;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt_q == '0) begin
                        tx_q       <= 1'b1;
                        tx_cnt_q   <= STOP_LOAD;
                        tx_state_q <= TX_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == '0) begin
                        // Ready rises on the same edge the FSM re-enters idle.
                        tx_ready_q <= en;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    tx_q       <= 1'b1;
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign uart_tx      = tx_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.tx_busy  = (tx_state_q != TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    logic [1:0]        rx_sync_q;
    logic              rx_s;
    rx_state_t         rx_state_q;
    logic [CNT_W-1:0]  rx_cnt_q;
    logic [BIT_W-1:0]  rx_bit_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic              rx_perr_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              rx_parity_err_q;
    logic              rx_frame_err_q;
    logic              rx_overrun_q;
    logic              rx_take;

    // Idle-high synchroniser so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], uart_rx};
        end
    end

    assign rx_s    = rx_sync_q[1];
    assign rx_take = rx_valid_q && bus.rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q      <= RX_IDLE;
            rx_cnt_q        <= '0;
            rx_bit_q        <= '0;
            rx_shift_q      <= '0;
            rx_perr_q       <= 1'b0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
            rx_overrun_q    <= 1'b0;
        end else begin
            // A read this cycle is applied first; a word landing on the same
            // edge overrides rx_valid below, giving read-then-write ordering.
            if (rx_take) begin
                rx_valid_q   <= 1'b0;
                rx_overrun_q <= 1'b0;
            end

            if (!en) begin
                rx_state_q <= RX_IDLE;
            end else begin
                case (rx_state_q)
                    RX_IDLE: begin
                        if (!rx_s) begin
                            rx_cnt_q   <= HALF_LOAD;
                            rx_state_q <= RX_START;
                        end
                    end
                    RX_START: begin
                        if (rx_cnt_q == '0) begin
                            if (rx_s) begin
                                rx_state_q <= RX_IDLE;
                            end else begin
                                rx_bit_q   <= '0;
                                rx_cnt_q   <= BIT_LOAD;
                                rx_state_q <= RX_DATA;
                            end
                        end else begin
                            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                        end
                    end
                    RX_DATA: begin
                        if (rx_cnt_q == '0) begin
                            // LSB-first: shift in from the top.
                            rx_shift_q <= {rx_s, rx_shift_q[DATA_W-1:1]};
                            rx_cnt_q   <= BIT_LOAD;
                            if (rx_bit_q == LAST_BIT) begin
                                rx_state_q <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit_q <= rx_bit_q + BIT_W'(1);
                            end
                        end else begin
                            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                        end
                    end
                    RX_PARITY: begin
                        if (rx_cnt_q == '0) begin
                            rx_perr_q  <= rx_s ^ (^rx_shift_q) ^ ODD;
                            rx_cnt_q   <= BIT_LOAD;
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                        end
                    end
                    RX_STOP: begin
                        if (rx_cnt_q == '0) begin
                            rx_data_q       <= rx_shift_q;
                            rx_parity_err_q <= (PARITY != 0) && rx_perr_q;
                            rx_frame_err_q  <= !rx_s;
                            rx_valid_q      <= 1'b1;
                            if (rx_valid_q && !rx_take) begin
                                rx_overrun_q <= 1'b1;
                            end
                            // A low stop (break) must clear before re-arming.
                            rx_state_q <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                        end else begin
                            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                        end
                    end
                    RX_WAIT_HIGH: begin
                        if (rx_s) begin
                            rx_state_q <= RX_IDLE;
                        end
                    end
                    default: rx_state_q <= RX_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_parity_err_q;
    assign bus.rx_frame_err  = rx_frame_err_q;
    assign bus.rx_overrun    = rx_overrun_q;

endmodule
